// File: rtl/pc_link_pkg.sv
// Shared constants for the PC byte link: slot framing, word size and error-bit layout.
package pc_link_pkg;

  localparam int          SLOT_STROBES     = 4;
  localparam logic [7:0]  PAD_BYTE         = 8'h00;
  localparam int          BYTES_PER_WORD   = 4;
  localparam int          NOMINAL_SLOT_CYC = 12433;

  localparam int          ERR_PAD = 0;
  localparam int          ERR_TO  = 1;

endpackage

// File: rtl/frompc_slot.sv
// Slot framer: tracks strobe position within a 4-strobe slot, checks pad bytes and
// times out a partial word; emits data-byte valid, pad-error and timeout pulses.
module frompc_slot
  import pc_link_pkg::*;
#(
  parameter int TO_W        = 16,
  parameter int TIMEOUT_CYC = 2 * NOMINAL_SLOT_CYC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       strobe,
  input  logic [7:0] data,
  input  logic       word_part,
  output logic       byte_vld,
  output logic       pad_err,
  output logic       timeout,
  output logic       part
);

  localparam logic [TO_W-1:0] TO_LIM   = TO_W'(TIMEOUT_CYC);
  localparam logic [1:0]      DATA_POS = 2'(SLOT_STROBES - 1);

  logic [1:0]      sub;
  logic [TO_W-1:0] idle;
  logic [TO_W-1:0] idle_inc;

  assign part     = (sub != 2'd0) || word_part;
  assign byte_vld = strobe && (sub == DATA_POS);
  assign pad_err  = strobe && (sub != DATA_POS) && (data != PAD_BYTE);
  assign idle_inc = (&idle) ? idle : idle + TO_W'(1);
  // Fires on the edge where the idle count would reach the limit, so the
  // error is visible exactly TIMEOUT_CYC clocks after the last strobe.
  assign timeout  = !strobe && part && (idle_inc == TO_LIM);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sub  <= 2'd0;
      idle <= '0;
    end else if (clr) begin
      sub  <= 2'd0;
      idle <= '0;
    end else if (strobe) begin
      idle <= '0;
      if (byte_vld || pad_err) sub <= 2'd0;
      else                     sub <= sub + 2'd1;
    end else if (timeout || !part) begin
      sub  <= 2'd0;
      idle <= '0;
    end else begin
      idle <= idle_inc;
    end
  end

endmodule

// File: rtl/frompc_rx.sv
// PC link receiver: assembles four data bytes (LSB first) into a 32-bit word and
// writes it to RAM with an auto-incrementing address; flags pad errors and timeouts.
module frompc_rx
  import pc_link_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int TO_W        = 16,
  parameter int TIMEOUT_CYC = 2 * NOMINAL_SLOT_CYC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rxen,
  input  logic [7:0]        rxpcdata,
  input  logic              clrflag,
  output logic              we,
  output logic [ADDR_W-1:0] w_addr,
  output logic [31:0]       w_data,
  output logic              busy,
  output logic [1:0]        err,
  output logic              done
);

  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  logic [1:0]  bcnt;
  logic [31:0] shift;
  logic        strobe;
  logic        byte_vld;
  logic        pad_err;
  logic        timeout;
  logic        part;

  // A full memory or a same-cycle clear swallows the strobe entirely.
  assign strobe = rxen && !done && !clrflag;

  frompc_slot #(
    .TO_W        (TO_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_slot (
    .clk       (clk),
    .rst       (rst),
    .clr       (clrflag),
    .strobe    (strobe),
    .data      (rxpcdata),
    .word_part (bcnt != 2'd0),
    .byte_vld  (byte_vld),
    .pad_err   (pad_err),
    .timeout   (timeout),
    .part      (part)
  );

  assign busy = part;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we     <= 1'b0;
      w_addr <= '0;
      w_data <= '0;
      err    <= 2'b00;
      done   <= 1'b0;
      bcnt   <= 2'd0;
      shift  <= '0;
    end else begin
      we <= 1'b0;
      if (clrflag) begin
        err    <= 2'b00;
        done   <= 1'b0;
        w_addr <= '0;
        bcnt   <= 2'd0;
        shift  <= '0;
      end else begin
        if (we) w_addr <= w_addr + ADDR_W'(1);
        if (pad_err || timeout) begin
          bcnt  <= 2'd0;
          shift <= '0;
        end
        if (pad_err) err[ERR_PAD] <= 1'b1;
        if (timeout) err[ERR_TO]  <= 1'b1;
        if (byte_vld) begin
          if (bcnt == LAST_BYTE) begin
            we     <= 1'b1;
            w_data <= {rxpcdata, shift[23:0]};
            bcnt   <= 2'd0;
            shift  <= '0;
            if (&w_addr) done <= 1'b1;
          end else begin
            shift[{bcnt, 3'b000} +: 8] <= rxpcdata;
            bcnt <= bcnt + 2'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_frompc_rx.sv
// Directed bench for frompc_rx: default-size instance for framing/reset cases,
// small instance (ADDR_W=2, TIMEOUT_CYC=50) for timeout and fill cases.
module tb_frompc_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rxen = 1'b0;
  logic [7:0]  rxpcdata = 8'h00;
  logic        clrflag = 1'b0;

  logic        we_a, busy_a, done_a;
  logic [7:0]  w_addr_a;
  logic [31:0] w_data_a;
  logic [1:0]  err_a;

  logic        we_b, busy_b, done_b;
  logic [1:0]  w_addr_b;
  logic [31:0] w_data_b;
  logic [1:0]  err_b;

  int checks = 0;
  int errors = 0;
  int we_cnt_a = 0;
  int we_cnt_b = 0;
  int base;

  always #5 clk = ~clk;

  frompc_rx #(.ADDR_W(8), .TO_W(16), .TIMEOUT_CYC(24866)) dut_a (
    .clk(clk), .rst(rst), .rxen(rxen), .rxpcdata(rxpcdata), .clrflag(clrflag),
    .we(we_a), .w_addr(w_addr_a), .w_data(w_data_a), .busy(busy_a),
    .err(err_a), .done(done_a)
  );

  frompc_rx #(.ADDR_W(2), .TO_W(16), .TIMEOUT_CYC(50)) dut_b (
    .clk(clk), .rst(rst), .rxen(rxen), .rxpcdata(rxpcdata), .clrflag(clrflag),
    .we(we_b), .w_addr(w_addr_b), .w_data(w_data_b), .busy(busy_b),
    .err(err_b), .done(done_b)
  );

  always @(negedge clk) begin
    if (we_a) we_cnt_a++;
    if (we_b) we_cnt_b++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; the strobe is sampled on the following posedge.
  task automatic strobe(input logic [7:0] b);
    rxen = 1'b1;
    rxpcdata = b;
    @(negedge clk);
    rxen = 1'b0;
    rxpcdata = 8'h00;
  endtask

  task automatic send_strobes(input logic [31:0] w, input int n, input int gap);
    logic [7:0] b;
    for (int j = 0; j < n; j++) begin
      b = (j % 4 == 3) ? w[8*(j/4) +: 8] : 8'h00;
      strobe(b);
      if (j != n - 1) repeat (gap) @(negedge clk);
    end
  endtask

  task automatic pulse_clr();
    clrflag = 1'b1;
    @(negedge clk);
    clrflag = 1'b0;
  endtask

  initial begin
    // reset state
    #2;
    check("rst_we_a", {31'd0, we_a}, 32'd0);
    check("rst_addr_a", {24'd0, w_addr_a}, 32'd0);
    check("rst_data_a", w_data_a, 32'd0);
    check("rst_flags_a", {28'd0, busy_a, err_a, done_a}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // normal word, 100-clock gaps
    base = we_cnt_a;
    send_strobes(32'hDEADBEEF, 16, 100);
    check("norm_we", {31'd0, we_a}, 32'd1);
    check("norm_data", w_data_a, 32'hDEADBEEF);
    check("norm_addr", {24'd0, w_addr_a}, 32'd0);
    @(negedge clk);
    check("norm_we_drop", {31'd0, we_a}, 32'd0);
    check("norm_addr_inc", {24'd0, w_addr_a}, 32'd1);
    check("norm_busy", {31'd0, busy_a}, 32'd0);
    check("norm_err", {30'd0, err_a}, 32'd0);
    check("norm_we_cnt", we_cnt_a - base, 32'd1);

    // pad error in the second slot, then a clean word
    pulse_clr();
    base = we_cnt_a;
    send_strobes(32'h00000044, 4, 2);
    check("pad_busy_before", {31'd0, busy_a}, 32'd1);
    strobe(8'h00);
    strobe(8'h05);
    check("pad_err", {30'd0, err_a}, 32'd1);
    check("pad_busy", {31'd0, busy_a}, 32'd0);
    check("pad_no_we", we_cnt_a - base, 32'd0);
    send_strobes(32'h11223344, 16, 2);
    check("pad_rec_we", {31'd0, we_a}, 32'd1);
    check("pad_rec_data", w_data_a, 32'h11223344);
    check("pad_rec_addr", {24'd0, w_addr_a}, 32'd0);
    @(negedge clk);
    check("pad_err_sticky", {30'd0, err_a}, 32'd1);

    // async reset mid-word
    send_strobes(32'hFFFFFFFF, 9, 2);
    check("ar_busy_before", {31'd0, busy_a}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("ar_addr", {24'd0, w_addr_a}, 32'd0);
    check("ar_data", w_data_a, 32'd0);
    check("ar_flags", {28'd0, busy_a, err_a, done_a}, 32'd0);
    check("ar_we", {31'd0, we_a}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    send_strobes(32'hCAFEF00D, 16, 1);
    check("ar_rec_we", {31'd0, we_a}, 32'd1);
    check("ar_rec_data", w_data_a, 32'hCAFEF00D);
    check("ar_rec_addr", {24'd0, w_addr_a}, 32'd0);
    @(negedge clk);

    // clrflag together with the completing strobe
    base = we_cnt_a;
    send_strobes(32'h55667788, 15, 1);
    rxen = 1'b1;
    rxpcdata = 8'h55;
    clrflag = 1'b1;
    @(negedge clk);
    rxen = 1'b0;
    rxpcdata = 8'h00;
    clrflag = 1'b0;
    @(negedge clk);
    check("sim_no_we", we_cnt_a - base, 32'd0);
    check("sim_err", {30'd0, err_a}, 32'd0);
    check("sim_addr", {24'd0, w_addr_a}, 32'd0);
    check("sim_busy", {31'd0, busy_a}, 32'd0);

    // timeout on the small instance
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    base = we_cnt_b;
    send_strobes(32'h0, 6, 2);
    repeat (49) @(negedge clk);
    check("to_err_early", {30'd0, err_b}, 32'd0);
    check("to_busy_early", {31'd0, busy_b}, 32'd1);
    @(negedge clk);
    check("to_err", {30'd0, err_b}, 32'd2);
    check("to_busy", {31'd0, busy_b}, 32'd0);
    repeat (10) @(negedge clk);
    check("to_no_we", we_cnt_b - base, 32'd0);
    send_strobes(32'hA5A55A5A, 16, 2);
    check("to_rec_we", {31'd0, we_b}, 32'd1);
    check("to_rec_data", w_data_b, 32'hA5A55A5A);
    check("to_rec_addr", {30'd0, w_addr_b}, 32'd0);
    @(negedge clk);

    // fill the 4-word memory
    pulse_clr();
    for (int k = 1; k <= 4; k++) begin
      send_strobes(32'(k), 16, 0);
      check("fill_we", {31'd0, we_b}, 32'd1);
      check("fill_data", w_data_b, 32'(k));
      check("fill_addr", {30'd0, w_addr_b}, 32'(k - 1));
      @(negedge clk);
    end
    check("fill_done", {31'd0, done_b}, 32'd1);
    check("fill_wrap", {30'd0, w_addr_b}, 32'd0);
    base = we_cnt_b;
    send_strobes(32'h5, 16, 0);
    repeat (2) @(negedge clk);
    check("fill_ignored", we_cnt_b - base, 32'd0);
    check("fill_busy_full", {31'd0, busy_b}, 32'd0);
    pulse_clr();
    check("fill_clr_done", {31'd0, done_b}, 32'd0);
    send_strobes(32'h00000006, 16, 0);
    check("fill_after_clr_we", {31'd0, we_b}, 32'd1);
    check("fill_after_clr_addr", {30'd0, w_addr_b}, 32'd0);
    check("fill_after_clr_data", w_data_b, 32'h00000006);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
